tx_sched: RTL and testbench
===========================

TX_SCHED -- requirements
Module: tx_sched

Interface
REQ-001 clk_sys  in  1  system clock; all state updates on rising edge.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 trig  in  [0:2]  one-cycle send requests; index 0 = reset source, 1 = CP status source, 2 = bus source.
REQ-004 done  in  1  serializer pulse: current frame fully sent to UART.
REQ-005 ovr_clr  in  1  clears all overrun flags.
REQ-006 ena  out  [0:2]  one-hot grant; the granted source drives cmd/args onto the OR-combined message fields.
REQ-007 start  out  1  one-cycle pulse telling the serializer to latch the fields and begin a frame.
REQ-008 busy  out  1  high in any state other than IDLE.
REQ-009 overrun  out  [0:2]  sticky per-source flag: a request arrived while the same source was already pending.
REQ-010 wdt  out  1  one-cycle pulse when the serializer watchdog aborts a frame.

Function
REQ-011 pending[i] SHALL set on the edge after trig[i]=1, and SHALL clear only on frame completion or abort for source i.
REQ-012 trig[i]=1 while pending[i]=1 SHALL set overrun[i]; the request merges and no second frame is queued.
REQ-013 FSM states: IDLE, START, WAIT, GAP.
REQ-014 IDLE: if any pending bit is set, select a winner, set ena to one-hot(winner) and start=1, then go to START; otherwise hold.
REQ-015 START lasts exactly 1 cycle; on exit start=0, ena held, and the FSM goes to WAIT.
REQ-016 done SHALL be ignored outside WAIT.
REQ-017 WAIT: on done, clear pending[winner], set ena=0, go to GAP.
REQ-018 GAP lasts 1 cycle with ena=0, then returns to IDLE; consecutive grants are separated by at least 1 idle-ena cycle.
REQ-019 Latency: trig sampled at edge E0 -> ena/start high after E1 when the FSM is IDLE with nothing pending.
REQ-020 If trig[winner] and done arrive in the same cycle, pending[winner] SHALL remain set (new request wins) and overrun SHALL NOT set.
REQ-021 Watchdog: 8-bit counter cleared on entering WAIT and incremented each WAIT cycle.
REQ-022 Watchdog abort: at count 255 without done, pulse wdt, clear pending[winner], set ena=0, go to GAP.
REQ-023 ena SHALL be one-hot or zero at all times and SHALL NOT change while in START or WAIT.
REQ-024 ovr_clr and a same-cycle overrun set on the same bit: the set wins.

Reset
REQ-025 rst_n=0 SHALL immediately force state=IDLE, pending=0, ena=0, start=0, overrun=0, wdt=0, watchdog=0, and RR pointer=2.
REQ-026 Reset during WAIT SHALL abandon the frame without a wdt pulse; the serializer is reset by the same rst_n.

Configuration
REQ-027 Macro TX_SCHED_RR_EN defined: round-robin; the search starts at (last served + 1) mod 3, and the pointer updates when a grant is issued.
REQ-028 Macro TX_SCHED_RR_EN undefined: fixed priority 0 > 1 > 2; no pointer logic is synthesized.

Verification
REQ-029 Single request: trig=3'b001 one cycle, done 10 cycles after start -> ena=3'b001 and start pulse 1 edge after pending sets; ena=0 for 1 GAP cycle; busy low after.
REQ-030 Simultaneous requests: trig=3'b111 one cycle -> fixed priority grants 0,1,2; with RR_EN from reset, also 0,1,2; then trig=3'b101 again -> RR grants 2 then 0 only if pointer=1 (check pointer sequence).
REQ-031 Overrun: pending[1] set, trig=3'b010 again -> overrun=3'b010 sticky, exactly one frame sent; ovr_clr -> overrun=0.
REQ-032 Watchdog: grant source 2, never assert done -> wdt pulse exactly 256 cycles after entering WAIT, pending[2]=0, ena=0.
REQ-033 Re-request at completion: trig[0] coincident with done for source 0 -> a second frame for source 0 starts after GAP; overrun stays 0.
REQ-034 Async reset in WAIT: drop rst_n mid-frame -> all outputs 0 before the next clock edge; no wdt pulse.

Source files
------------

// File: rtl/tx_sched.sv
// tx_sched -- transmit scheduler for three message sources sharing one UART
// serializer.
//
// Each source raises a one-cycle trig pulse to request a frame. Requests latch
// into pending bits. The FSM then grants one source at a time: it asserts the
// one-hot ena, pulses start, and waits for the serializer's done pulse. An
// 8-bit watchdog aborts a frame that never completes.
//
// Build option: TX_SCHED_RR_EN
//   defined   -> round-robin arbitration; the search starts after the last
//                source served.
//   undefined -> fixed priority, 0 > 1 > 2.
//
// Ports
//   clk_sys      in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   trig[0:2]    in   send requests (0 = reset src, 1 = CP status, 2 = bus)
//   done         in   serializer finished the current frame
//   ovr_clr      in   clear all sticky overrun flags
//   ena[0:2]     out  one-hot grant (or zero)
//   start        out  one-cycle pulse: serializer latches fields, begins frame
//   busy         out  FSM is not IDLE
//   overrun[0:2] out  sticky: request arrived while the source was pending
//   wdt          out  one-cycle pulse: watchdog aborted the frame
module tx_sched (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic [0:2] trig,
  input  logic       done,
  input  logic       ovr_clr,
  output logic [0:2] ena,
  output logic       start,
  output logic       busy,
  output logic [0:2] overrun,
  output logic       wdt
);

  typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;

  state_t     state_q, state_d;
  logic [0:2] pending_q, pending_d;
  logic [0:2] ena_q, ena_d;
  logic [0:2] ovr_q, ovr_d;
  logic       start_q, start_d;
  logic       wdt_q, wdt_d;
  logic [7:0] wdog_q, wdog_d;
  logic [0:2] grant;    // one-hot winner among pending sources
  logic [0:2] clr;      // pending bits retired this cycle
  logic [0:2] ovr_set;

`ifdef TX_SCHED_RR_EN
  // ptr_q holds the last source served; the search begins one past it.
  logic [1:0] ptr_q, ptr_d;

  always_comb begin
    grant = '0;
    case (ptr_q)
      2'd0: begin
        if      (pending_q[1]) grant[1] = 1'b1;
        else if (pending_q[2]) grant[2] = 1'b1;
        else if (pending_q[0]) grant[0] = 1'b1;
      end
      2'd1: begin
        if      (pending_q[2]) grant[2] = 1'b1;
        else if (pending_q[0]) grant[0] = 1'b1;
        else if (pending_q[1]) grant[1] = 1'b1;
      end
      default: begin
        if      (pending_q[0]) grant[0] = 1'b1;
        else if (pending_q[1]) grant[1] = 1'b1;
        else if (pending_q[2]) grant[2] = 1'b1;
      end
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == IDLE && |pending_q)
      ptr_d = grant[1] ? 2'd1 : (grant[2] ? 2'd2 : 2'd0);
  end

  always_ff @(posedge clk_sys or negedge rst_n)
    if (!rst_n) ptr_q <= 2'd2;
    else        ptr_q <= ptr_d;
`else
  always_comb begin
    grant    = '0;
    grant[0] = pending_q[0];
    grant[1] = pending_q[1] & ~pending_q[0];
    grant[2] = pending_q[2] & ~pending_q[0] & ~pending_q[1];
  end
`endif

  always_comb begin
    state_d = state_q;
    ena_d   = ena_q;
    start_d = 1'b0;
    wdt_d   = 1'b0;
    wdog_d  = wdog_q;
    clr     = '0;
    case (state_q)
      IDLE: if (|pending_q) begin
        ena_d   = grant;
        start_d = 1'b1;
        state_d = START;
      end
      START: begin
        wdog_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // ena_q still holds the winner, so it doubles as the retire mask.
        if (done) begin
          clr     = ena_q;
          ena_d   = '0;
          state_d = GAP;
        end else if (wdog_q == 8'hFF) begin
          wdt_d   = 1'b1;
          clr     = ena_q;
          ena_d   = '0;
          state_d = GAP;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
      end
      default: state_d = IDLE;  // GAP
    endcase

    // A request that coincides with its own completion is a fresh request,
    // not an overrun; it keeps the bit pending for another frame.
    ovr_set   = trig & pending_q & ~clr;
    pending_d = (pending_q & ~clr) | trig;
    ovr_d     = (ovr_q & ~{3{ovr_clr}}) | ovr_set;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      ena_q     <= '0;
      ovr_q     <= '0;
      start_q   <= 1'b0;
      wdt_q     <= 1'b0;
      wdog_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ena_q     <= ena_d;
      ovr_q     <= ovr_d;
      start_q   <= start_d;
      wdt_q     <= wdt_d;
      wdog_q    <= wdog_d;
    end
  end

  assign ena     = ena_q;
  assign start   = start_q;
  assign busy    = (state_q != IDLE);
  assign overrun = ovr_q;
  assign wdt     = wdt_q;

endmodule

// File: tb/tb_tx_sched.sv
module tb_tx_sched;
  logic       clk_sys = 1'b0;
  logic       rst_n, done, ovr_clr;
  logic [0:2] trig;
  logic [0:2] ena, overrun;
  logic       start, busy, wdt;

  int n_vec = 0;
  int n_err = 0;
  int exp_q[$];   // expected grant order, pushed by stimulus

  tx_sched dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .trig(trig), .done(done),
    .ovr_clr(ovr_clr), .ena(ena), .start(start), .busy(busy),
    .overrun(overrun), .wdt(wdt)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic logic [0:2] oh(input int i);
    logic [0:2] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every start pulse pops the next expected grant.
  always @(negedge clk_sys) begin
    int s;
    if (rst_n === 1'b1 && start === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL grant: unexpected start ena=%b (t=%0t)", ena, $time);
      end else begin
        s = exp_q.pop_front();
        chk("grant_ena", ena, oh(s));
      end
    end
  end

  // All tasks begin and end just after a falling edge.
  task automatic pulse_trig(input logic [0:2] v);
    trig = v;
    @(negedge clk_sys);
    trig = '0;
  endtask

  task automatic wait_start(output int n);
    n = 0;
    do begin
      @(negedge clk_sys);
      n++;
    end while (start !== 1'b1 && n < 60);
    if (start !== 1'b1) chk("start_timeout", 0, 1);
  endtask

  // Called at the START negedge; completes the frame after lat WAIT cycles.
  task automatic finish_frame(input int src, input int lat);
    repeat (lat) @(negedge clk_sys);
    chk("ena_hold", ena, oh(src));
    done = 1'b1;
    @(negedge clk_sys);
    done = 1'b0;
    chk("gap_ena", ena, 0);
    chk("gap_busy", busy, 1);
    @(negedge clk_sys);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n, k;
    int ord[2];
    bit seen;
    rst_n = 1'b0; trig = '0; done = 1'b0; ovr_clr = 1'b0;
    #12;
    chk("rst_ena", ena, 0);
    chk("rst_start", start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_wdt", wdt, 0);
    @(negedge clk_sys);
    rst_n = 1'b1;
    @(negedge clk_sys);

    // Single request, with a stray done during START that must be ignored.
    exp_q.push_back(0);
    pulse_trig(oh(0));
    wait_start(n);
    chk("latency", n, 1);
    done = 1'b1;
    @(negedge clk_sys);
    done = 1'b0;
    chk("stray_done_ena", ena, oh(0));
    chk("stray_done_busy", busy, 1);
    finish_frame(0, 9);

    // Simultaneous requests, then 0 and 2.
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    pulse_trig(3'b111);
    for (int s = 0; s < 3; s++) begin
      wait_start(n);
      finish_frame(s, 3);
    end
    exp_q.push_back(0); exp_q.push_back(2);
    pulse_trig(oh(0) | oh(2));
    wait_start(n); finish_frame(0, 2);
    wait_start(n); finish_frame(2, 2);

    // Serve 0 alone, then 0 and 2 together: round-robin should favour 2.
    exp_q.push_back(0);
    pulse_trig(oh(0));
    wait_start(n); finish_frame(0, 2);
`ifdef TX_SCHED_RR_EN
    ord[0] = 2; ord[1] = 0;
`else
    ord[0] = 0; ord[1] = 2;
`endif
    exp_q.push_back(ord[0]); exp_q.push_back(ord[1]);
    pulse_trig(oh(0) | oh(2));
    wait_start(n); finish_frame(ord[0], 2);
    wait_start(n); finish_frame(ord[1], 2);

    // Overrun: trig[1] held two cycles merges into one frame.
    exp_q.push_back(1);
    trig = oh(1);
    @(negedge clk_sys);
    @(negedge clk_sys);
    trig = '0;
    chk("overrun_set", overrun, oh(1));
    @(negedge clk_sys);
    trig = oh(1); ovr_clr = 1'b1;       // set and clear collide: set wins
    @(negedge clk_sys);
    trig = '0; ovr_clr = 1'b0;
    chk("overrun_set_wins", overrun, oh(1));
    finish_frame(1, 3);
    repeat (5) @(negedge clk_sys);
    chk("overrun_sticky", overrun, oh(1));
    ovr_clr = 1'b1;
    @(negedge clk_sys);
    ovr_clr = 1'b0;
    chk("overrun_clr", overrun, 0);

    // Re-request coincident with done: a second frame, no overrun.
    exp_q.push_back(0); exp_q.push_back(0);
    pulse_trig(oh(0));
    wait_start(n);
    repeat (3) @(negedge clk_sys);
    done = 1'b1; trig = oh(0);
    @(negedge clk_sys);
    done = 1'b0; trig = '0;
    chk("rereq_gap_ena", ena, 0);
    @(negedge clk_sys);
    wait_start(n);
    chk("rereq_overrun", overrun, 0);
    finish_frame(0, 2);

    // Watchdog on source 2.
    exp_q.push_back(2);
    pulse_trig(oh(2));
    wait_start(n);
    k = 0;
    do begin
      @(negedge clk_sys);
      k++;
    end while (wdt !== 1'b1 && k < 300);
    chk("wdt_delay", k, 257);
    chk("wdt_ena", ena, 0);
    chk("wdt_busy", busy, 1);
    @(negedge clk_sys);
    chk("wdt_width", wdt, 0);
    repeat (5) @(negedge clk_sys);
    chk("wdt_pending_clr", busy, 0);

    // Async reset mid-frame, with an overrun flag raised first.
    exp_q.push_back(0);
    trig = oh(0);
    @(negedge clk_sys);
    @(negedge clk_sys);
    trig = '0;
    chk("pre_rst_overrun", overrun, oh(0));
    repeat (3) @(negedge clk_sys);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ena", ena, 0);
    chk("arst_start", start, 0);
    chk("arst_busy", busy, 0);
    chk("arst_overrun", overrun, 0);
    chk("arst_wdt", wdt, 0);
    @(negedge clk_sys);
    @(negedge clk_sys);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_sys);
      if (wdt === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    chk("arst_quiet", seen, 0);

    chk("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
